// File: rtl/branch_pred_unit.sv
// ---------------------------------------------------------------------------
// branch_pred_unit
//   Branch prediction unit for the pipelined RV32I datapath. A direct-mapped
//   BTB supplies targets and a table of 2-bit saturating counters (PHT)
//   supplies direction. The PHT is indexed by PC (PRED_MODE=0, bimodal) or by
//   PC xor global history (PRED_MODE=1, gshare). Prediction is same-cycle
//   combinational; tables and history update on the clock edge of a resolve.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   fetch_pc            PC presented by IF this cycle
//   pred_taken          predicted taken
//   pred_target         predicted next PC (fetch_pc+4 when not taken)
//   pred_idx            PHT index used, carried down the pipe
//   res_valid           EX holds a resolved branch/jump this cycle
//   res_is_jump         resolved instruction is JAL/JALR
//   res_pc              PC of resolved instruction
//   res_taken           actual direction
//   res_target          actual taken target
//   res_pred_taken      carried pred_taken
//   res_pred_target     carried pred_target
//   res_pred_idx        carried pred_idx (used as PHT update index)
//   mispredict          resolved prediction was wrong
//   redirect_pc         correct next PC when mispredict=1
//   stat_branches       resolved count (only with BPU_STATS_EN)
//   stat_correct        correctly predicted count (only with BPU_STATS_EN)
//
// Configuration macro
//   BPU_STATS_EN        when defined, saturating statistics counters are
//                       built; otherwise both stat outputs are constant zero.
// ---------------------------------------------------------------------------
module branch_pred_unit #(
  parameter int unsigned PHT_IDX_W = 10,
  parameter int unsigned BHR_W     = 10,
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned PRED_MODE = 1,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          fetch_pc,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic [PHT_IDX_W-1:0] pred_idx,
  input  logic                 res_valid,
  input  logic                 res_is_jump,
  input  logic [31:0]          res_pc,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  input  logic                 res_pred_taken,
  input  logic [31:0]          res_pred_target,
  input  logic [PHT_IDX_W-1:0] res_pred_idx,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_correct
);

  localparam int unsigned PHT_N = 32'd1 << PHT_IDX_W;
  localparam int unsigned BTB_N = 32'd1 << BTB_IDX_W;
  localparam int unsigned TAG_W = 32 - BTB_IDX_W - 2;

  logic [1:0]           pht [PHT_N];
  logic [BTB_N-1:0]     btb_valid;
  logic [BTB_N-1:0]     btb_jump;
  logic [TAG_W-1:0]     btb_tag [BTB_N];
  logic [31:0]          btb_tgt [BTB_N];
  logic [BHR_W-1:0]     bhr;

  logic [PHT_IDX_W-1:0] bhr_ext;
  logic [BTB_IDX_W-1:0] fetch_btb_i;
  logic                 btb_hit;
  logic [BTB_IDX_W-1:0] res_btb_i;
  logic [1:0]           ctr_old;
  logic [1:0]           ctr_next;
  logic [BHR_W:0]       bhr_shift;

  assign res_btb_i = res_pc[BTB_IDX_W+1:2];
  assign bhr_shift = {bhr, res_taken};

  // Fetch-side lookup: BTB hit check, PHT index and prediction.
  always_comb begin
    bhr_ext = '0;
    bhr_ext[BHR_W-1:0] = bhr;
    fetch_btb_i = fetch_pc[BTB_IDX_W+1:2];
    btb_hit = btb_valid[fetch_btb_i] &
              (btb_tag[fetch_btb_i] == fetch_pc[31:BTB_IDX_W+2]);
    if (PRED_MODE != 32'd0) begin
      pred_idx = fetch_pc[PHT_IDX_W+1:2] ^ bhr_ext;
    end else begin
      pred_idx = fetch_pc[PHT_IDX_W+1:2];
    end
    // Without a BTB hit there is no target, so the counter is ignored.
    pred_taken = ~rst & btb_hit & (btb_jump[fetch_btb_i] | pht[pred_idx][1]);
    if (pred_taken) begin
      pred_target = btb_tgt[fetch_btb_i];
    end else begin
      pred_target = fetch_pc + 32'd4;
    end
  end

  // Resolve-side check: misprediction flag and correct next PC.
  always_comb begin
    mispredict = ~rst & res_valid &
                 ((res_taken != res_pred_taken) |
                  (res_taken & (res_target != res_pred_target)));
    if (res_taken) begin
      redirect_pc = res_target;
    end else begin
      redirect_pc = res_pc + 32'd4;
    end
  end

  // Saturating counter step for the carried PHT entry.
  always_comb begin
    ctr_old  = pht[res_pred_idx];
    ctr_next = ctr_old;
    if (res_taken) begin
      if (ctr_old == 2'b11) ctr_next = 2'b11;
      else                  ctr_next = ctr_old + 2'b01;
    end else begin
      if (ctr_old == 2'b00) ctr_next = 2'b00;
      else                  ctr_next = ctr_old - 2'b01;
    end
  end

  // PHT storage; jumps never train the direction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pht <= '{default: CTR_INIT};
    end else if (res_valid && !res_is_jump) begin
      pht[res_pred_idx] <= ctr_next;
    end
  end

  // BTB valid/jump bits; only taken resolves allocate (replace on conflict).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
      btb_jump  <= '0;
    end else if (res_valid && res_taken) begin
      btb_valid[res_btb_i] <= 1'b1;
      btb_jump[res_btb_i]  <= res_is_jump;
    end
  end

  // BTB tag/target payload; qualified by the valid bit, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && res_valid && res_taken) begin
      btb_tag[res_btb_i] <= res_pc[31:BTB_IDX_W+2];
      btb_tgt[res_btb_i] <= res_target;
    end
  end

  // Global history, shifted in resolve order only (non-speculative).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bhr <= '0;
    end else if (res_valid) begin
      bhr <= bhr_shift[BHR_W-1:0];
    end
  end

`ifdef BPU_STATS_EN
  // Saturating prediction statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= 32'h0;
      stat_correct  <= 32'h0;
    end else if (res_valid) begin
      if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
      if (!mispredict && (stat_correct != 32'hFFFF_FFFF)) stat_correct <= stat_correct + 32'd1;
    end
  end
`else
  assign stat_branches = 32'h0;
  assign stat_correct  = 32'h0;
`endif

endmodule
